key_event_decoder: RTL and testbench



---
 rtl/key_event_pkg.sv | 15 +
 rtl/key_event_decoder_if.sv | 30 +++
 rtl/edge_detect.sv | 26 ++
 rtl/key_event_decoder.sv | 132 +++++++++++++
 tb/tb_key_event_decoder.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_event_pkg.sv
// Shared key-UI constants: decoder state encoding and default
// gesture timings at 1 MHz.
package key_event_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_PRESS1 = 3'd1;
   localparam logic [2:0] ST_WAIT2  = 3'd2;
   localparam logic [2:0] ST_PRESS2 = 3'd3;
   localparam logic [2:0] ST_LONG   = 3'd4;

   localparam int LONG_1S   = 1_000_000;
   localparam int GAP_300MS = 300_000;
   localparam int REP_200MS = 200_000;

endpackage

// File: rtl/key_event_decoder_if.sv
// Key level in, gesture strobes out; master drives the key,
// slave is the decoder.
interface key_event_decoder_if;

   logic key_i;
   logic short_o;
   logic double_o;
   logic long_o;
   logic repeat_o;
   logic held_o;

   modport master (
      output key_i,
      input  short_o,
      input  double_o,
      input  long_o,
      input  repeat_o,
      input  held_o
   );

   modport slave (
      input  key_i,
      output short_o,
      output double_o,
      output long_o,
      output repeat_o,
      output held_o
   );

endinterface

// File: rtl/edge_detect.sv
// One-register edge detector for an already synchronous,
// glitch-free level.
module edge_detect (
   input  logic clk_1m_i,
   input  logic rst_i,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic d_q;
   logic d_d;

   assign d_d    = d_i;
   assign rise_o = d_i & ~d_q;
   assign fall_o = ~d_i & d_q;

   always_ff @(posedge clk_1m_i or posedge rst_i) begin
      if (rst_i) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d_d;
      end
   end

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key gestures into short / double / long
// press strobes with auto-repeat while a long press is held.
module key_event_decoder
   import key_event_pkg::*;
#(
   parameter int CNT_W       = 21,
   parameter int LONG_CYC    = LONG_1S,
   parameter int DBL_GAP_CYC = GAP_300MS,
   parameter int REPEAT_CYC  = REP_200MS
) (
   input  logic                clk_1m_i,
   input  logic                rst_i,
   key_event_decoder_if.slave  ev
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(DBL_GAP_CYC - 1);
   localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_CYC - 1);

   logic rise;
   logic fall;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             short_q, short_d;
   logic             double_q, double_d;
   logic             long_q, long_d;
   logic             repeat_q, repeat_d;
   logic             held_q, held_d;

   edge_detect u_edge (
      .clk_1m_i (clk_1m_i),
      .rst_i    (rst_i),
      .d_i      (ev.key_i),
      .rise_o   (rise),
      .fall_o   (fall)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      short_d  = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      held_d   = held_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (rise) begin
               state_d = ST_PRESS1;
            end
         end
         ST_PRESS1: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == LONG_M1) begin
               state_d = ST_LONG;
               cnt_d   = '0;
               long_d  = 1'b1;
               held_d  = 1'b1;
            end else if (fall) begin
               state_d = ST_WAIT2;
               cnt_d   = '0;
            end
         end
         ST_WAIT2: begin
            cnt_d = cnt_q + CNT_ONE;
            if (rise) begin
               state_d = ST_PRESS2;
               cnt_d   = '0;
            end else if (cnt_q == GAP_M1) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               short_d = 1'b1;
            end
         end
         ST_PRESS2: begin
            cnt_d = '0;
            if (fall) begin
               state_d  = ST_IDLE;
               double_d = 1'b1;
            end
         end
         ST_LONG: begin
            cnt_d = cnt_q + CNT_ONE;
            // level test: a release that lost to the long threshold
            // already consumed its fall edge in PRESS1
            if (!ev.key_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               held_d  = 1'b0;
            end else if (cnt_q == REP_M1) begin
               cnt_d    = '0;
               repeat_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_1m_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         short_q  <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
         repeat_q <= 1'b0;
         held_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         short_q  <= short_d;
         double_q <= double_d;
         long_q   <= long_d;
         repeat_q <= repeat_d;
         held_q   <= held_d;
      end
   end

   assign ev.short_o  = short_q;
   assign ev.double_o = double_q;
   assign ev.long_o   = long_q;
   assign ev.repeat_o = repeat_q;
   assign ev.held_o   = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed gestures plus random
// press/release trains against a time-stamp based gesture model.
module tb_key_event_decoder;

   localparam int LONG = 20;
   localparam int GAP  = 10;
   localparam int REP  = 5;

   localparam int M_IDLE = 0;
   localparam int M_P1   = 1;
   localparam int M_GAP  = 2;
   localparam int M_P2   = 3;
   localparam int M_LONG = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   key_event_decoder_if bus ();

   key_event_decoder #(
      .CNT_W       (21),
      .LONG_CYC    (LONG),
      .DBL_GAP_CYC (GAP),
      .REPEAT_CYC  (REP)
   ) dut (
      .clk_1m_i (clk),
      .rst_i    (rst),
      .ev       (bus)
   );

   int checks = 0;
   int errors = 0;

   // gesture model: phases with start time stamps
   int   mode = M_IDLE;
   int   cyc  = 0;
   int   t0   = 0;
   logic prev = 1'b0;
   logic e_s = 1'b0, e_d = 1'b0, e_l = 1'b0, e_r = 1'b0, e_h = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mode <= M_IDLE;
         prev <= 1'b0;
         e_s <= 1'b0; e_d <= 1'b0; e_l <= 1'b0; e_r <= 1'b0; e_h <= 1'b0;
      end else begin
         cyc  <= cyc + 1;
         prev <= bus.key_i;
         e_s <= 1'b0; e_d <= 1'b0; e_l <= 1'b0; e_r <= 1'b0;
         e_h <= (mode == M_LONG);
         case (mode)
            M_IDLE: if (bus.key_i && !prev) begin
               mode <= M_P1; t0 <= cyc;
            end
            M_P1: if (cyc - t0 == LONG) begin
               mode <= M_LONG; t0 <= cyc; e_l <= 1'b1; e_h <= 1'b1;
            end else if (!bus.key_i) begin
               mode <= M_GAP; t0 <= cyc;
            end
            M_GAP: if (bus.key_i && !prev) begin
               mode <= M_P2;
            end else if (cyc - t0 == GAP) begin
               mode <= M_IDLE; e_s <= 1'b1;
            end
            M_P2: if (!bus.key_i) begin
               mode <= M_IDLE; e_d <= 1'b1;
            end
            default: if (!bus.key_i) begin
               mode <= M_IDLE; e_h <= 1'b0;
            end else if ((cyc - t0) % REP == 0) begin
               e_r <= 1'b1;
            end
         endcase
      end
   end

   logic [4:0] got_v, exp_v;
   assign got_v = {bus.short_o, bus.double_o, bus.long_o,
                   bus.repeat_o, bus.held_o};
   assign exp_v = {e_s, e_d, e_l, e_r, e_h};

   int mon_err = 0;
   int n_s = 0, n_d = 0, n_l = 0, n_r = 0;
   int x_s = 0, x_d = 0, x_l = 0, x_r = 0;

   always @(negedge clk) begin
      if (got_v !== exp_v) begin
         mon_err <= mon_err + 1;
         $display("FAIL trace t=%0t got=%b exp=%b", $time, got_v, exp_v);
      end
      n_s <= n_s + int'(bus.short_o);
      n_d <= n_d + int'(bus.double_o);
      n_l <= n_l + int'(bus.long_o);
      n_r <= n_r + int'(bus.repeat_o);
      x_s <= x_s + int'(e_s);
      x_d <= x_d + int'(e_d);
      x_l <= x_l + int'(e_l);
      x_r <= x_r + int'(e_r);
   end

   task automatic hold(input logic k, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1 bus.key_i = k;
      end
   endtask

   task automatic test_reset();
      bus.key_i = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (got_v !== 5'b0) begin
         errors++;
         $display("FAIL reset_outs got %b exp 00000", got_v);
      end
      bus.key_i = 1'b0;
      rst = 1'b0;
      hold(1'b0, 5);
      checks++;
      if (got_v !== 5'b0) begin
         errors++;
         $display("FAIL idle_outs got %b exp 00000", got_v);
      end
   endtask

   task automatic test_short();
      int s0, d0, l0, pos;
      s0 = n_s; d0 = n_d; l0 = n_l; pos = -1;
      hold(1'b1, 5);
      @(negedge clk);
      #1 bus.key_i = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         #1;
         if (bus.short_o) pos = i;
      end
      checks++;
      if (n_s - s0 !== 1) begin
         errors++;
         $display("FAIL short_cnt got %0d exp 1", n_s - s0);
      end
      checks++;
      if (pos !== GAP + 1) begin
         errors++;
         $display("FAIL short_pos got %0d exp %0d", pos, GAP + 1);
      end
      checks++;
      if ((n_d - d0) + (n_l - l0) !== 0) begin
         errors++;
         $display("FAIL short_other got %0d exp 0", (n_d - d0) + (n_l - l0));
      end
   endtask

   task automatic test_double(input int gap);
      int s0, d0;
      s0 = n_s; d0 = n_d;
      hold(1'b1, 5);
      hold(1'b0, gap);
      hold(1'b1, 3);
      hold(1'b0, 20);
      checks++;
      if (n_d - d0 !== 1) begin
         errors++;
         $display("FAIL double_cnt gap=%0d got %0d exp 1", gap, n_d - d0);
      end
      checks++;
      if (n_s - s0 !== 0) begin
         errors++;
         $display("FAIL double_noshort gap=%0d got %0d exp 0", gap, n_s - s0);
      end
   endtask

   task automatic test_long();
      int l0, r0, s0;
      l0 = n_l; r0 = n_r; s0 = n_s;
      hold(1'b1, 32);
      checks++;
      if (bus.held_o !== 1'b1) begin
         errors++;
         $display("FAIL long_held got %b exp 1", bus.held_o);
      end
      hold(1'b0, 1);
      @(negedge clk);
      #1;
      checks++;
      if (bus.held_o !== 1'b0) begin
         errors++;
         $display("FAIL long_drop got %b exp 0", bus.held_o);
      end
      hold(1'b0, 20);
      checks++;
      if (n_l - l0 !== 1) begin
         errors++;
         $display("FAIL long_cnt got %0d exp 1", n_l - l0);
      end
      checks++;
      if (n_r - r0 !== 2) begin
         errors++;
         $display("FAIL repeat_cnt got %0d exp 2", n_r - r0);
      end
      checks++;
      if (n_s - s0 !== 0) begin
         errors++;
         $display("FAIL long_noshort got %0d exp 0", n_s - s0);
      end
   endtask

   task automatic test_long_wins();
      int l0, s0, r0;
      l0 = n_l; s0 = n_s; r0 = n_r;
      hold(1'b1, LONG);
      hold(1'b0, 25);
      checks++;
      if (n_l - l0 !== 1) begin
         errors++;
         $display("FAIL longwin_cnt got %0d exp 1", n_l - l0);
      end
      checks++;
      if ((n_s - s0) + (n_r - r0) !== 0) begin
         errors++;
         $display("FAIL longwin_other got %0d exp 0", (n_s - s0) + (n_r - r0));
      end
      checks++;
      if (bus.held_o !== 1'b0) begin
         errors++;
         $display("FAIL longwin_idle got %b exp 0", bus.held_o);
      end
   endtask

   task automatic test_reset_mid();
      int s0, l0;
      s0 = n_s;
      hold(1'b1, 5);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (got_v !== 5'b0) begin
         errors++;
         $display("FAIL rst_press1 got %b exp 00000", got_v);
      end
      bus.key_i = 1'b0;
      @(negedge clk);
      #1 rst = 1'b0;
      hold(1'b0, 20);
      checks++;
      if (n_s - s0 !== 0) begin
         errors++;
         $display("FAIL rst_abort got %0d exp 0", n_s - s0);
      end
      hold(1'b1, LONG + 3);
      checks++;
      if (bus.held_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_prelong got %b exp 1", bus.held_o);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (got_v !== 5'b0) begin
         errors++;
         $display("FAIL rst_long got %b exp 00000", got_v);
      end
      @(negedge clk);
      #1 rst = 1'b0;
      l0 = n_l;
      hold(1'b1, LONG + 2);
      checks++;
      if (n_l - l0 !== 1) begin
         errors++;
         $display("FAIL rst_newpress got %0d exp 1", n_l - l0);
      end
      hold(1'b0, 20);
   endtask

   task automatic test_random();
      int s0, d0, l0, r0, xs0, xd0, xl0, xr0;
      s0 = n_s; d0 = n_d; l0 = n_l; r0 = n_r;
      xs0 = x_s; xd0 = x_d; xl0 = x_l; xr0 = x_r;
      for (int g = 0; g < 60; g++) begin
         hold(1'b1, int'($urandom_range(1, 34)));
         hold(1'b0, int'($urandom_range(1, 14)));
      end
      hold(1'b0, 20);
      checks++;
      if (n_s - s0 !== x_s - xs0) begin
         errors++;
         $display("FAIL rnd_short got %0d exp %0d", n_s - s0, x_s - xs0);
      end
      checks++;
      if (n_d - d0 !== x_d - xd0) begin
         errors++;
         $display("FAIL rnd_double got %0d exp %0d", n_d - d0, x_d - xd0);
      end
      checks++;
      if (n_l - l0 !== x_l - xl0) begin
         errors++;
         $display("FAIL rnd_long got %0d exp %0d", n_l - l0, x_l - xl0);
      end
      checks++;
      if (n_r - r0 !== x_r - xr0) begin
         errors++;
         $display("FAIL rnd_repeat got %0d exp %0d", n_r - r0, x_r - xr0);
      end
   endtask

   task automatic test_trace();
      checks++;
      if (mon_err !== 0) begin
         errors++;
         $display("FAIL trace_total got %0d exp 0", mon_err);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL timeout");
      $fatal(1, "time limit");
   end

   initial begin
      bus.key_i = 1'b0;
      test_reset();
      test_short();
      test_double(4);
      test_long();
      test_double(GAP);
      test_long_wins();
      test_reset_mid();
      test_random();
      test_trace();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
